// File: rtl/teclado_scan.sv
// Matrix-keypad scanner: walks the columns, synchronises the rows,
// debounces press and release, and encodes the accepted key.
module teclado_scan #(
    parameter int FILAS    = 4,
    parameter int COLUMNAS = 4,
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 1000,
    localparam int CW      = $clog2(FILAS * COLUMNAS)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [FILAS-1:0]    Fila,
    output logic [COLUMNAS-1:0] Columna,
    output logic                botonApretado,
    output logic [CW-1:0]       tecla,
    output logic                teclaValida
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int KW = (COLUMNAS > 1) ? $clog2(COLUMNAS) : 1;
    localparam int RW = (FILAS > 1) ? $clog2(FILAS) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST = BW'(DEBOUNCE - 1);
    localparam logic [KW-1:0] COL_LAST = KW'(COLUMNAS - 1);

    typedef enum logic [1:0] {
        ESCANEO,
        REBOTE_ON,
        APRETADO,
        REBOTE_OFF
    } estado_t;

    estado_t state_q, state_d;

    logic [FILAS-1:0] sync1, fila_s;
    logic [KW-1:0]    col_q, col_d, col_inc;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    deb_q, deb_d;
    logic [RW-1:0]    fila_q, fila_d, low_row;
    logic [CW-1:0]    tecla_q, tecla_d, key_code;
    logic             valid_q, valid_d;
    logic             boton_q, boton_d;
    logic             row_hit;

    // Two-flop synchroniser on the raw row pins
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1  <= '0;
            fila_s <= '0;
        end else begin
            sync1  <= Fila;
            fila_s <= sync1;
        end
    end

    // Lowest-index high row wins when several are pressed together
    always_comb begin
        low_row = '0;
        for (int i = FILAS - 1; i >= 0; i--) begin
            if (fila_s[i]) begin
                low_row = RW'(i);
            end
        end
    end

    assign col_inc  = (col_q == COL_LAST) ? '0 : col_q + KW'(1);
    assign row_hit  = fila_s[fila_q];
    assign key_code = CW'(int'(fila_q) * COLUMNAS + int'(col_q));

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        div_d   = div_q;
        deb_d   = deb_q;
        fila_d  = fila_q;
        tecla_d = tecla_q;
        boton_d = boton_q;
        valid_d = 1'b0;
        unique case (state_q)
            ESCANEO: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (|fila_s) begin
                        fila_d  = low_row;
                        deb_d   = '0;
                        state_d = REBOTE_ON;
                    end else begin
                        col_d = col_inc;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            REBOTE_ON: begin
                if (!row_hit) begin
                    state_d = ESCANEO;
                    div_d   = '0;
                    col_d   = col_inc;
                end else if (deb_q == DEB_LAST) begin
                    state_d = APRETADO;
                    tecla_d = key_code;
                    valid_d = 1'b1;
                    boton_d = 1'b1;
                end else begin
                    deb_d = deb_q + BW'(1);
                end
            end
            APRETADO: begin
                if (!row_hit) begin
                    deb_d   = '0;
                    state_d = REBOTE_OFF;
                end
            end
            REBOTE_OFF: begin
                if (row_hit) begin
                    state_d = APRETADO;
                end else if (deb_q == DEB_LAST) begin
                    state_d = ESCANEO;
                    boton_d = 1'b0;
                    col_d   = col_inc;
                    div_d   = '0;
                end else begin
                    deb_d = deb_q + BW'(1);
                end
            end
            default: begin
                state_d = ESCANEO;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ESCANEO;
            col_q   <= '0;
            div_q   <= '0;
            deb_q   <= '0;
            fila_q  <= '0;
            tecla_q <= '0;
            valid_q <= 1'b0;
            boton_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            div_q   <= div_d;
            deb_q   <= deb_d;
            fila_q  <= fila_d;
            tecla_q <= tecla_d;
            valid_q <= valid_d;
            boton_q <= boton_d;
        end
    end

    always_comb begin
        Columna        = '0;
        Columna[col_q] = 1'b1;
    end

    assign tecla         = tecla_q;
    assign teclaValida   = valid_q;
    assign botonApretado = boton_q;

endmodule
